// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential quadrant multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [1:0] quad_idx_t;

  // Left-shift applied to quadrant i, packed as {q3, q2, q1, q0}.
  localparam logic [15:0] QUAD_SHIFTS = {4'd8, 4'd4, 4'd4, 4'd0};

  localparam logic [3:0] DEFAULT_APPROX_MASK = 4'b1100;

  function automatic logic [3:0] quad_shift(input quad_idx_t qi);
    return QUAD_SHIFTS[{qi, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle for mult_seq_ctrl.
interface mult_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      r;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, r, busy, op_cnt
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, r, busy, op_cnt
  );
endinterface

// File: rtl/quad_mul_4x4.sv
// Combinational 4x4 unsigned multiplier; approx mode clears the two LSBs of the product.
module quad_mul_4x4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       approx,
  output logic [7:0] p
);
  logic [7:0] w_exact;

  assign w_exact = {4'd0, a4} * {4'd0, b4};
  assign p       = approx ? {w_exact[7:2], 2'b00} : w_exact;
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 core, four accumulate cycles per operand pair.
// Optional feature: define MULT_ZERO_SKIP_EN to send zero-operand pairs straight to DONE.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter logic [3:0] APPROX_MASK = DEFAULT_APPROX_MASK,
  parameter int         CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_seq_ctrl_if.slave  s_if
);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_mode;
  quad_idx_t        r_qi;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_op_cnt;

  logic             w_accept;
  logic             w_release;
  logic [3:0]       w_a4;
  logic [3:0]       w_b4;
  logic             w_approx;
  logic [7:0]       w_p;
  logic [15:0]      w_term;

  assign w_accept  = s_if.in_valid  && (r_state == ST_IDLE);
  assign w_release = s_if.out_ready && (r_state == ST_DONE);

  // qi[1] picks the high nibble of a, qi[0] the high nibble of b.
  assign w_a4     = r_qi[1] ? r_a[7:4] : r_a[3:0];
  assign w_b4     = r_qi[0] ? r_b[7:4] : r_b[3:0];
  assign w_approx = r_mode & APPROX_MASK[r_qi];
  assign w_term   = {8'd0, w_p} << quad_shift(r_qi);

  quad_mul_4x4 u_quad_mul (
    .a4     (w_a4),
    .b4     (w_b4),
    .approx (w_approx),
    .p      (w_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef MULT_ZERO_SKIP_EN
          if ((s_if.a == 8'd0) || (s_if.b == 8'd0)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_MUL;
          end
`else
          w_state_next = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        if (r_qi == 2'd3) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (s_if.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_qi     <= '0;
      r_acc    <= '0;
      r_op_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= s_if.a;
        r_b    <= s_if.b;
        r_mode <= s_if.mode;
        r_qi   <= '0;
        r_acc  <= '0;
      end else if (r_state == ST_MUL) begin
        r_acc <= r_acc + w_term;
        r_qi  <= r_qi + 2'd1;
      end
      if (w_release) begin
        r_op_cnt <= r_op_cnt + 1'b1;
      end
    end
  end

  assign s_if.in_ready  = (r_state == ST_IDLE);
  assign s_if.out_valid = (r_state == ST_DONE);
  assign s_if.busy      = (r_state != ST_IDLE);
  assign s_if.r         = r_acc;
  assign s_if.op_cnt    = r_op_cnt;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential controller for the 8x8 quadrant-decomposed approximate multiplier. It accepts one operand pair per transaction over a valid/ready handshake and computes the 8x8 product in four cycles on a single shared 4x4 sub-multiplier. It accumulates the shifted partial products and returns a 16-bit result over a second valid/ready handshake. It sits between an operand-producing stream (image/NN datapath) and its consumer, where area matters more than throughput. Per-transaction `mode` selects the exact result or the approximate result.

## Interface
- `APPROX_MASK`, 4'b1100: per-quadrant approximation enable when `mode`=1. Bit i applies to quadrant i.
- `CNT_W`, 16: width of the completed-operation counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept.
- `a` in 8: multiplicand.
- `b` in 8: multiplier.
- `mode` in 1: 0 = exact, 1 = approximate per `APPROX_MASK`. Sampled at accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `r` out 16: product.
- `busy` out 1: high in every state except IDLE.
- `op_cnt` out CNT_W: completed result handshakes, wraps modulo 2^CNT_W.

## Operation
- Quadrants:
  - q0 = a[3:0]·b[3:0]
  - q1 = a[3:0]·b[7:4]
  - q2 = a[7:4]·b[3:0]
  - q3 = a[7:4]·b[7:4]
- Result: r = q0 + (q1<<4) + (q2<<4) + (q3<<8). Accumulate in 16 bits. No overflow is possible (max 0xFE01).
- 4x4 rule: the exact product is an 8-bit unsigned product. The approximate product is the exact product with bits [1:0] forced to 0. Quadrant i is approximate iff latched mode=1 and APPROX_MASK[i]=1.
- FSM states:
  - IDLE: `in_ready`=1. Accept (in_valid & in_ready) latches a, b, mode, clears the accumulator and the quadrant counter, then goes to MUL.
  - MUL: 2-bit quadrant counter qi runs 0..3. Each cycle adds the shifted, optionally approximated q[qi] to the accumulator. After qi=3, go to DONE.
  - DONE: `out_valid`=1 and `r` = accumulator, held stable. On out_valid & out_ready: increment `op_cnt` and go to IDLE.
- `in_valid` outside IDLE is ignored. Operands need not be held after accept.
- `out_ready` outside DONE is ignored.
- No bypass: `in_ready` rises on the cycle after the result handshake.
- Reset, asserted at any time including mid-MUL: state goes to IDLE immediately and the transaction is discarded. Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `r`=0
  - `op_cnt`=0
  - accumulator=0
  - qi=0
  - latched operands=0

## Timing
- Accept at edge E0.
- Quadrants q0..q3 are accumulated at edges E1..E4.
- `out_valid` goes high after E4, i.e. 4 cycles after accept (zero-skip: 1 cycle).
- Minimum initiation interval is 6 cycles: 4 MUL cycles, 1 DONE cycle with immediate `out_ready`, and 1 IDLE cycle.
- Backpressure holds DONE indefinitely. `r` stays constant while held.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- `MULT_ZERO_SKIP_EN` defined: at accept, if a==0 or b==0, go directly to DONE with accumulator=0, so `out_valid` is high 1 cycle after accept. `op_cnt` counts zero-skip results normally.
- `MULT_ZERO_SKIP_EN` undefined: every transaction takes the full 4 MUL cycles. The result is identical (0).

## Structure
- Shared package `mult_pkg`:
  - FSM state enum (IDLE, MUL, DONE).
  - Quadrant index type.
  - Quadrant shift constants {0,4,4,8}.
  - Default APPROX_MASK constant.
- One sub-module, `quad_mul_4x4`: inputs a4[3:0], b4[3:0], approx; output p[7:0]; purely combinational and instantiated once. Quadrant operand muxing, shifting and accumulation stay in `mult_seq_ctrl`.

## Test plan
- mode=0, a=0x12, b=0x34, out_ready=1 → out_valid 4 cycles after accept, r=0x03A8, op_cnt=1.
- mode=1 (default mask), a=0x12, b=0x34 → r=0x00A8. mode=0, a=b=0xFF → r=0xFE01. mode=1, a=b=0xFF → r=0xFCF1.
- Backpressure: out_ready low for 10 cycles in DONE → r and out_valid stable, in_ready=0, a second in_valid is ignored. Raising out_ready completes exactly one result.
- Reset pulse in MUL after 2 quadrants → all outputs at reset values asynchronously. The next transaction a=0x0F, b=0x0F, mode=0 gives r=0x00E1.
- a=0x00, b=0x5A: with MULT_ZERO_SKIP_EN, r=0 and out_valid 1 cycle after accept. Without it, r=0 after 4 cycles.
- 2^CNT_W+3 back-to-back random transactions against a golden model → all results match and op_cnt wraps to 3.
